// File: rtl/gate_owner_lock_pkg.sv
// Shared NoC router definitions: source ID encoding, handshake codes, gate
// indices and the owner-lock state type used by gate_owner_lock.
package noc_pkg;

   localparam int unsigned SRC_W = 4;
   localparam logic [SRC_W-1:0] FREE_ID = 4'hF;

   localparam logic [1:0] HS_NONE  = 2'b00;
   localparam logic [1:0] HS_SEND  = 2'b01;
   localparam logic [1:0] HS_RECV  = 2'b10;
   localparam logic [1:0] HS_ABORT = 2'b11;

   localparam int unsigned GATE_N  = 0;
   localparam int unsigned GATE_E  = 1;
   localparam int unsigned GATE_S  = 2;
   localparam int unsigned GATE_W  = 3;
   localparam int unsigned GATE_IP = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLAIM,
      ST_LOCKED,
      ST_RELEASE
   } lock_state_t;

endpackage

// File: rtl/gate_owner_lock_idle_timer.sv
// Idle-cycle counter for a locked gate; expire is a combinational terminal
// pulse on the TIMEOUT-th consecutive idle cycle while enabled.
module gate_idle_timer #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic activity,
   output logic expire
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] idle_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || !en || activity) begin
         idle_cnt <= '0;
      end else if (idle_cnt != TW'(TIMEOUT)) begin
         idle_cnt <= idle_cnt + TW'(1);
      end
   end

   assign expire = en && !activity && (idle_cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/gate_owner_lock.sv
// Per-output-gate owner register: claims the gate for one source and holds it
// for a packet. Optional idle timeout via macro GATE_LOCK_TIMEOUT_EN.
module gate_owner_lock
   import noc_pkg::*;
#(
   parameter int unsigned     SRC_W     = noc_pkg::SRC_W,
   parameter logic [SRC_W-1:0] FREE_ID  = noc_pkg::FREE_ID,
   parameter int unsigned     MAX_FLITS = 16
`ifdef GATE_LOCK_TIMEOUT_EN
   ,
   parameter int unsigned     TIMEOUT   = 64
`endif
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           req_valid,
   input  logic [SRC_W-1:0]               req_source,
   input  logic [1:0]                     req_type,
   input  logic                           dn_ack,
   input  logic                           flit_valid,
   input  logic                           flit_tail,
   output logic [SRC_W-1:0]               owner_source,
   output logic                           locked,
   output logic                           req_grant,
   output logic [$clog2(MAX_FLITS):0]     flit_count,
   output logic                           release_pulse
`ifdef GATE_LOCK_TIMEOUT_EN
   ,
   output logic                           timeout_flag
`endif
);

   localparam int unsigned CW = $clog2(MAX_FLITS) + 1;

   lock_state_t   state;
   logic          owner_abort;
   logic          tail_seen;
   logic          cap_hit;
   logic          timeout_hit;
   logic [CW-1:0] count_nxt;

   assign owner_abort = req_valid && (req_type == HS_ABORT) && (req_source == owner_source);
   assign tail_seen   = flit_valid && flit_tail;
   assign count_nxt   = (flit_valid && (flit_count != CW'(MAX_FLITS))) ? flit_count + CW'(1)
                                                                       : flit_count;
   assign cap_hit     = (count_nxt == CW'(MAX_FLITS));

`ifdef GATE_LOCK_TIMEOUT_EN
   logic timeout_seen;

   gate_idle_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_idle_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (state == ST_LOCKED),
      .activity (flit_valid),
      .expire   (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   // Release outputs appear on leaving RELEASE, so the owner clears two edges
   // after the tail and requests seen during RELEASE are dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         owner_source  <= FREE_ID;
         locked        <= 1'b0;
         req_grant     <= 1'b0;
         flit_count    <= '0;
         release_pulse <= 1'b0;
`ifdef GATE_LOCK_TIMEOUT_EN
         timeout_flag  <= 1'b0;
         timeout_seen  <= 1'b0;
`endif
      end else begin
         req_grant     <= 1'b0;
         release_pulse <= 1'b0;
`ifdef GATE_LOCK_TIMEOUT_EN
         timeout_flag  <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (req_valid && (req_type == HS_SEND) && (req_source != FREE_ID)) begin
                  owner_source <= req_source;
                  locked       <= 1'b1;
                  req_grant    <= 1'b1;
                  flit_count   <= '0;
                  state        <= ST_CLAIM;
               end
            end
            ST_CLAIM: begin
               if (owner_abort) begin
                  state <= ST_RELEASE;
               end else if (dn_ack) begin
                  flit_count <= '0;
                  state      <= ST_LOCKED;
               end
            end
            ST_LOCKED: begin
               flit_count <= count_nxt;
`ifdef GATE_LOCK_TIMEOUT_EN
               timeout_seen <= timeout_hit;
`endif
               if (tail_seen || cap_hit || owner_abort || timeout_hit) begin
                  state <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               owner_source  <= FREE_ID;
               locked        <= 1'b0;
               release_pulse <= 1'b1;
`ifdef GATE_LOCK_TIMEOUT_EN
               timeout_flag  <= timeout_seen;
               timeout_seen  <= 1'b0;
`endif
               state         <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
